// File: rtl/ctl_xfer_seq_if.sv
// EP0 control-transfer sequencer bus: SETUP fields, responder request/grant,
// the two responder IN streams, the packetiser IN stream and latched fields.
interface ctl_xfer_seq_if;
  logic        setup_valid_i;
  logic [7:0]  setup_type_i;
  logic [7:0]  setup_request_i;
  logic [15:0] setup_value_i;
  logic [15:0] setup_index_i;
  logic [15:0] setup_length_i;
  logic        status_done_i;

  logic        std_req_o;
  logic        usr_req_o;
  logic        std_gnt_i;
  logic        usr_gnt_i;

  logic        std_tvalid_i;
  logic        std_tlast_i;
  logic [7:0]  std_tdata_i;
  logic        std_tready_o;

  logic        usr_tvalid_i;
  logic        usr_tlast_i;
  logic [7:0]  usr_tdata_i;
  logic        usr_tready_o;

  logic        ctl_tvalid_o;
  logic        ctl_tlast_o;
  logic [7:0]  ctl_tdata_o;
  logic        ctl_tready_i;

  logic [7:0]  xfer_type_o;
  logic [7:0]  xfer_request_o;
  logic [15:0] xfer_value_o;
  logic [15:0] xfer_index_o;
  logic [15:0] xfer_length_o;
  logic        stall_o;

  modport slave (
    input  setup_valid_i, setup_type_i, setup_request_i, setup_value_i,
           setup_index_i, setup_length_i, status_done_i,
           std_gnt_i, usr_gnt_i,
           std_tvalid_i, std_tlast_i, std_tdata_i,
           usr_tvalid_i, usr_tlast_i, usr_tdata_i,
           ctl_tready_i,
    output std_req_o, usr_req_o, std_tready_o, usr_tready_o,
           ctl_tvalid_o, ctl_tlast_o, ctl_tdata_o,
           xfer_type_o, xfer_request_o, xfer_value_o, xfer_index_o,
           xfer_length_o, stall_o
  );

  modport master (
    output setup_valid_i, setup_type_i, setup_request_i, setup_value_i,
           setup_index_i, setup_length_i, status_done_i,
           std_gnt_i, usr_gnt_i,
           std_tvalid_i, std_tlast_i, std_tdata_i,
           usr_tvalid_i, usr_tlast_i, usr_tdata_i,
           ctl_tready_i,
    input  std_req_o, usr_req_o, std_tready_o, usr_tready_o,
           ctl_tvalid_o, ctl_tlast_o, ctl_tdata_o,
           xfer_type_o, xfer_request_o, xfer_value_o, xfer_index_o,
           xfer_length_o, stall_o
  );
endinterface

// File: rtl/ctl_xfer_seq.sv
// EP0 control-transfer sequencer: latches SETUP, routes the request to the
// standard or user responder, forwards its IN data with packet/length framing.
// Optional macro CTL_XFER_TIMEOUT_EN adds a grant-wait timeout into STALL.
//
// state  | meaning
// IDLE   | no transfer; outputs quiet
// GRANT  | request raised to the selected responder, waiting for gnt
// DATA   | IN data forwarded from the selected responder
// STATUS | data done, req held until the host finishes the status stage
// STALL  | unsupported or failed request; only a new SETUP leaves
module ctl_xfer_seq #(
  parameter int MAX_PACKET     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic           clock,
  input logic           reset,
  ctl_xfer_seq_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GRANT, DATA, STATUS, STALL} state_t;

  state_t      state, state_nxt;
  logic        sel_usr;
  logic        fresh;      // first GRANT cycle after a SETUP: req held low
  logic [15:0] byte_cnt;
  logic [6:0]  pkt_cnt;
  logic [7:0]  type_q, request_q;
  logic [15:0] value_q, index_q, length_q;

  logic        src_tvalid, src_tlast, src_gnt;
  logic [7:0]  src_tdata;
  logic        in_data, req_active, beat, len_hit, pkt_hit, timeout_hit;

  assign in_data    = (state == DATA);
  assign req_active = ((state == GRANT) && !fresh) || in_data || (state == STATUS);
  assign len_hit    = ({1'b0, byte_cnt} + 17'd1) == {1'b0, length_q};
  assign pkt_hit    = (pkt_cnt == 7'(MAX_PACKET - 1));
  assign beat       = bus.ctl_tvalid_o && bus.ctl_tready_i;

  // Select the responder stream and grant named by the latched request type.
  always_comb begin
    src_tvalid = bus.std_tvalid_i;
    src_tlast  = bus.std_tlast_i;
    src_tdata  = bus.std_tdata_i;
    src_gnt    = bus.std_gnt_i;
    if (sel_usr) begin
      src_tvalid = bus.usr_tvalid_i;
      src_tlast  = bus.usr_tlast_i;
      src_tdata  = bus.usr_tdata_i;
      src_gnt    = bus.usr_gnt_i;
    end
  end

  assign bus.ctl_tvalid_o   = in_data && src_tvalid;
  assign bus.ctl_tdata_o    = in_data ? src_tdata : 8'h00;
  assign bus.ctl_tlast_o    = in_data && src_tvalid && (len_hit || src_tlast || pkt_hit);
  assign bus.std_tready_o   = in_data && !sel_usr && bus.ctl_tready_i;
  assign bus.usr_tready_o   = in_data &&  sel_usr && bus.ctl_tready_i;
  assign bus.std_req_o      = req_active && !sel_usr;
  assign bus.usr_req_o      = req_active &&  sel_usr;
  assign bus.stall_o        = (state == STALL);
  assign bus.xfer_type_o    = type_q;
  assign bus.xfer_request_o = request_q;
  assign bus.xfer_value_o   = value_q;
  assign bus.xfer_index_o   = index_q;
  assign bus.xfer_length_o  = length_q;

`ifdef CTL_XFER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_cnt;

  // Count cycles spent waiting in GRANT; restarts on every new SETUP.
  always_ff @(posedge clock) begin
    if (reset || (state != GRANT) || bus.setup_valid_i) tmo_cnt <= '0;
    else                                                 tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign timeout_hit = (state == GRANT) && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a new SETUP overrides everything, including status_done.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   state_nxt = IDLE;
      GRANT: begin
        if (req_active && src_gnt)
          state_nxt = (type_q[7] && (length_q != 16'd0)) ? DATA : STATUS;
        else if (timeout_hit)
          state_nxt = STALL;
      end
      DATA:   if (beat && (len_hit || src_tlast)) state_nxt = STATUS;
      STATUS: if (bus.status_done_i) state_nxt = IDLE;
      STALL:  state_nxt = STALL;
      default: state_nxt = IDLE;
    endcase
    if (bus.setup_valid_i)
      state_nxt = (bus.setup_type_i[6:5] == 2'b11) ? STALL : GRANT;
  end

  // Latch SETUP fields and target select; remember the req-drop cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      type_q    <= '0;
      request_q <= '0;
      value_q   <= '0;
      index_q   <= '0;
      length_q  <= '0;
      sel_usr   <= 1'b0;
      fresh     <= 1'b0;
    end else begin
      fresh <= bus.setup_valid_i;
      if (bus.setup_valid_i) begin
        type_q    <= bus.setup_type_i;
        request_q <= bus.setup_request_i;
        value_q   <= bus.setup_value_i;
        index_q   <= bus.setup_index_i;
        length_q  <= bus.setup_length_i;
        sel_usr   <= (bus.setup_type_i[6:5] != 2'b00);
      end
    end
  end

  // Byte and in-packet counters: cleared in GRANT, advanced per accepted beat.
  always_ff @(posedge clock) begin
    if (reset || bus.setup_valid_i || (state == GRANT)) begin
      byte_cnt <= '0;
      pkt_cnt  <= '0;
    end else if (beat) begin
      byte_cnt <= byte_cnt + 16'd1;
      pkt_cnt  <= pkt_hit ? 7'd0 : pkt_cnt + 7'd1;
    end
  end

endmodule

// File: tb/tb_ctl_xfer_seq.sv
// Directed bench for ctl_xfer_seq with a beat scoreboard.
module tb_ctl_xfer_seq;
  localparam int TMO = 32;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;
  logic [8:0] exp_q[$];
  logic [8:0] mon_e;

  ctl_xfer_seq_if bus();

  ctl_xfer_seq #(.MAX_PACKET(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Monitor: every accepted EP0 beat must match the head of the queue.
  always @(negedge clock) begin
    if (!reset && bus.ctl_tvalid_o && bus.ctl_tready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL beat_extra got last=%0b data=%02h, none expected", bus.ctl_tlast_o, bus.ctl_tdata_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({bus.ctl_tlast_o, bus.ctl_tdata_o} !== mon_e) begin
          failures++;
          $display("FAIL beat got last=%0b data=%02h, want last=%0b data=%02h",
                   bus.ctl_tlast_o, bus.ctl_tdata_o, mon_e[8], mon_e[7:0]);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic setup(input logic [7:0] t, input logic [7:0] r, input logic [15:0] v, input logic [15:0] l);
    bus.setup_valid_i   = 1'b1;
    bus.setup_type_i    = t;
    bus.setup_request_i = r;
    bus.setup_value_i   = v;
    bus.setup_index_i   = 16'h0000;
    bus.setup_length_i  = l;
    tick();
    bus.setup_valid_i   = 1'b0;
  endtask

  // Expects req low on the first GRANT cycle and high on the next one.
  task automatic grant(input bit usr);
    int i;
    for (i = 0; i < 10; i++) begin
      if ((usr ? bus.usr_req_o : bus.std_req_o) == 1'b1) break;
      tick();
    end
    check("req_rise_delay", i, 1);
    check("other_req_low", int'(usr ? bus.std_req_o : bus.usr_req_o), 0);
    if (usr) bus.usr_gnt_i = 1'b1; else bus.std_gnt_i = 1'b1;
    tick();
    bus.usr_gnt_i = 1'b0;
    bus.std_gnt_i = 1'b0;
  endtask

  task automatic finish_status(input bit usr);
    check("status_req", int'(usr ? bus.usr_req_o : bus.std_req_o), 1);
    check("status_tready", int'(bus.std_tready_o | bus.usr_tready_o), 0);
    bus.status_done_i = 1'b1;
    tick();
    bus.status_done_i = 1'b0;
    check("idle_req", int'(bus.std_req_o | bus.usr_req_o), 0);
  endtask

  function automatic logic [7:0] pat(input bit usr, input int i);
    return usr ? (8'(i) ^ 8'hA5) : 8'(i + 1);
  endfunction

  // Responder model: offers n_offer bytes, stops after n_take accepted
  // or when abort_at bytes have been accepted.
  task automatic stream(input bit usr, input int n_offer, input int n_take,
                        input int abort_at, input bit bp, output int taken);
    bit hs;
    taken = 0;
    for (int c = 0; c < 600 && taken < n_take; c++) begin
      if (taken == abort_at) break;
      if (usr) begin
        bus.usr_tvalid_i = 1'b1;
        bus.usr_tdata_i  = pat(1'b1, taken);
        bus.usr_tlast_i  = (taken == n_offer - 1);
      end else begin
        bus.std_tvalid_i = 1'b1;
        bus.std_tdata_i  = pat(1'b0, taken);
        bus.std_tlast_i  = (taken == n_offer - 1);
      end
      bus.ctl_tready_i = bp ? (c % 3 != 2) : 1'b1;
      @(negedge clock);
      hs = usr ? (bus.usr_tvalid_i && bus.usr_tready_o) : (bus.std_tvalid_i && bus.std_tready_o);
      tick();
      if (hs) taken++;
    end
    bus.std_tvalid_i = 1'b0; bus.std_tlast_i = 1'b0;
    bus.usr_tvalid_i = 1'b0; bus.usr_tlast_i = 1'b0;
    bus.ctl_tready_i = 1'b1;
  endtask

  task automatic push(input bit usr, input int n, input int last_a, input int last_b, input int last_c);
    for (int i = 1; i <= n; i++)
      exp_q.push_back({(i == last_a || i == last_b || i == last_c), pat(usr, i - 1)});
  endtask

  int taken;

  initial begin
    bus.setup_valid_i = 0; bus.setup_type_i = 0; bus.setup_request_i = 0;
    bus.setup_value_i = 0; bus.setup_index_i = 0; bus.setup_length_i = 0;
    bus.status_done_i = 0; bus.std_gnt_i = 0; bus.usr_gnt_i = 0;
    bus.std_tvalid_i = 0; bus.std_tlast_i = 0; bus.std_tdata_i = 0;
    bus.usr_tvalid_i = 0; bus.usr_tlast_i = 0; bus.usr_tdata_i = 0;
    bus.ctl_tready_i = 1;
    reset = 1'b1;
    repeat (3) tick();
    check("rst_req", int'(bus.std_req_o | bus.usr_req_o), 0);
    check("rst_stall", int'(bus.stall_o), 0);
    check("rst_tvalid", int'(bus.ctl_tvalid_o | bus.ctl_tlast_o), 0);
    check("rst_length", int'(bus.xfer_length_o), 0);
    reset = 1'b0;
    tick();

    // IDLE never forwards responder data.
    bus.std_tvalid_i = 1'b1;
    @(negedge clock);
    check("idle_tvalid", int'(bus.ctl_tvalid_o), 0);
    check("idle_tready", int'(bus.std_tready_o), 0);
    tick();
    bus.std_tvalid_i = 1'b0;

    // GET_DESCRIPTOR(device), std returns 18 bytes.
    setup(8'h80, 8'h06, 16'h0100, 16'd64);
    check("lat_type", int'(bus.xfer_type_o), 'h80);
    check("lat_length", int'(bus.xfer_length_o), 64);
    grant(1'b0);
    push(1'b0, 18, 18, -1, -1);
    stream(1'b0, 18, 18, -1, 1'b0, taken);
    check("gd18_beats", taken, 18);
    finish_status(1'b0);

    // Same request, wLength 8: truncated at 8 bytes.
    setup(8'h80, 8'h06, 16'h0100, 16'd8);
    grant(1'b0);
    push(1'b0, 8, 8, -1, -1);
    stream(1'b0, 18, 8, -1, 1'b0, taken);
    check("gd8_beats", taken, 8);
    bus.std_tvalid_i = 1'b1;
    @(negedge clock);
    check("gd8_tready_after", int'(bus.std_tready_o), 0);
    check("gd8_tvalid_after", int'(bus.ctl_tvalid_o), 0);
    tick();
    bus.std_tvalid_i = 1'b0;
    finish_status(1'b0);

    // 150-byte vendor IN from the user responder with backpressure.
    setup(8'hC0, 8'h01, 16'h0000, 16'd150);
    grant(1'b1);
    push(1'b1, 150, 64, 128, 150);
    stream(1'b1, 150, 150, -1, 1'b1, taken);
    check("usr150_beats", taken, 150);
    finish_status(1'b1);

    // SET_ADDRESS: no data stage.
    setup(8'h00, 8'h05, 16'h0007, 16'd0);
    check("lat_value", int'(bus.xfer_value_o), 7);
    check("lat_request", int'(bus.xfer_request_o), 5);
    grant(1'b0);
    bus.std_tvalid_i = 1'b1;
    @(negedge clock);
    check("setaddr_no_beat", int'(bus.ctl_tvalid_o), 0);
    tick();
    bus.std_tvalid_i = 1'b0;
    finish_status(1'b0);

    // Reserved type stalls; only a new SETUP clears it.
    setup(8'h60, 8'h00, 16'h0000, 16'd0);
    check("stall_set", int'(bus.stall_o), 1);
    check("stall_req", int'(bus.std_req_o | bus.usr_req_o), 0);
    bus.status_done_i = 1'b1;
    tick();
    bus.status_done_i = 1'b0;
    repeat (2) tick();
    check("stall_hold", int'(bus.stall_o), 1);
    setup(8'h00, 8'h05, 16'h0001, 16'd0);
    check("stall_clear", int'(bus.stall_o), 0);
    grant(1'b0);
    finish_status(1'b0);

    // New SETUP during DATA (after 5 of 18 bytes) restarts cleanly.
    setup(8'h80, 8'h06, 16'h0100, 16'd64);
    grant(1'b0);
    push(1'b0, 5, -1, -1, -1);
    stream(1'b0, 18, 18, 5, 1'b0, taken);
    check("abort_beats", taken, 5);
    check("abort_req_before", int'(bus.std_req_o), 1);
    setup(8'h80, 8'h06, 16'h0200, 16'd3);
    check("abort_req_drop", int'(bus.std_req_o), 0);
    grant(1'b0);
    push(1'b0, 3, 3, -1, -1);
    stream(1'b0, 18, 3, -1, 1'b0, taken);
    check("abort_new_beats", taken, 3);
    finish_status(1'b0);

    // setup_valid and status_done together: the SETUP wins.
    setup(8'h00, 8'h09, 16'h0001, 16'd0);
    grant(1'b0);
    bus.status_done_i = 1'b1;
    setup(8'h00, 8'h05, 16'h0003, 16'd0);
    bus.status_done_i = 1'b0;
    grant(1'b0);
    finish_status(1'b0);

`ifdef CTL_XFER_TIMEOUT_EN
    // No grant: STALL after TMO cycles in GRANT.
    begin
      int i;
      setup(8'h00, 8'h05, 16'h0004, 16'd0);
      for (i = 0; i < TMO + 10; i++) begin
        if (bus.stall_o) break;
        tick();
      end
      check("timeout_cycles", i, TMO);
      check("timeout_req", int'(bus.std_req_o), 0);
    end
`endif

    repeat (3) tick();
    check("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
